zynq_tag_serializer: RTL and testbench
======================================

# zynq_tag_serializer

Bit-serial packet generator that feeds the bsg_tag master driving the PL tag lines, including the `core_reset` client. It accepts one tag write per valid/ready handshake from the PS-side CSR register file. It emits the bsg_tag wire protocol one bit per `aclk` cycle on `tag_data_o`, after a power-on preamble of zero bits. It sits directly upstream of `bsg_tag_master`, which shares `aclk`.

## Interface
Parameters:
- `tag_els_p`, 16: number of tag clients.
- `tag_max_payload_width_p`, 1: maximum payload bits.
- `lg_els_lp`, `BSG_SAFE_CLOG2(tag_els_p)`: node-ID field width (4 at defaults).
- `lg_width_lp`, `BSG_SAFE_CLOG2(tag_max_payload_width_p+1)`: length field width (1 at defaults).
- `preamble_cycles_p`, 16: zero bits emitted after reset, before the first packet.
- `gap_cycles_p`, 2: minimum number of zero bits between packets (≥1).

Ports:
- `aclk`, input, 1: clock. One clock; reset is asynchronous and active-low.
- `aresetn`, input, 1: asynchronous active-low reset.
- `v_i`, input, 1: request valid.
- `ready_o`, output, 1: request accept.
- `node_id_i`, input, `lg_els_lp`: target client ID.
- `data_not_reset_i`, input, 1: 1 means data write; 0 means client reset.
- `len_i`, input, `lg_width_lp`: payload length in bits.
- `payload_i`, input, `tag_max_payload_width_p`: payload, LSB first.
- `tag_data_o`, output, 1: serial bit to `bsg_tag_master` `data_i`.
- `busy_o`, output, 1: high while the block is in PRE, SEND or GAP.

## Operation
- States: PRE, IDLE, SEND, GAP.
- PRE:
  - Entered on reset.
  - Emits `preamble_cycles_p` zeros, then goes to IDLE.
  - `ready_o`=0 throughout.
- IDLE:
  - `ready_o`=1 and `tag_data_o`=0.
  - On `v_i & ready_o`, the block latches all request fields into a shift register and goes to SEND.
- SEND emits the packet in this order:
  - start bit 1,
  - `node_id` (`lg_els_lp` bits, LSB first),
  - `data_not_reset` (1 bit),
  - `len` (`lg_width_lp` bits, LSB first),
  - `payload` (`len` bits, LSB first).
- Packet length is `3 + lg_els_lp + lg_width_lp - 1 + len` bits; at defaults that is 7+len.
- A down-counter loaded with the packet length at accept time ends SEND. After the last bit the block goes to GAP.
- GAP emits `gap_cycles_p` zeros, then returns to IDLE. `ready_o`=0 during GAP.
- If `len_i` > `tag_max_payload_width_p`, the block clamps `len_i` to `tag_max_payload_width_p` at latch time. The transmitted length field carries the clamped value.
- Inputs are sampled only on the accept edge. Changes on `v_i` or the data inputs while not ready have no effect.
- Reset mid-operation: all state clears asynchronously and `tag_data_o` drops to 0 immediately. The partial packet is abandoned and the PRE sequence restarts when `aresetn` deasserts. The preamble guarantees the master sees no false start bit.

## Timing
- Reset values: `tag_data_o`=0, `ready_o`=0, `busy_o`=1 (PRE), all counters 0.
- `ready_o` rises `preamble_cycles_p` cycles after the first `aclk` edge with `aresetn`=1.
- Accept on edge N puts the start bit on `tag_data_o` in cycle N+1; the output is registered.
- Each subsequent bit follows on consecutive cycles, with no bubbles.
- Back-to-back requests: the earliest next accept is `gap_cycles_p`+1 cycles after the last packet bit.
- Packet throughput at defaults (len=1): one packet per 8+2+1 = 11 cycles.
- `ready_o` and `busy_o` are combinational from state only and never depend on `v_i`.

## Configuration
- `ZYNQ_TAG_SERIALIZER_PKT_COUNT_EN`:
  - When defined, adds output port `pkt_count_o` [31:0].
  - Reset value 0.
  - Increments by 1 on the cycle the last bit of each packet is driven.
  - Wraps from 0xFFFFFFFF to 0.
- When undefined, the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset release: `tag_data_o`=0 and `ready_o`=0 for exactly 16 cycles, then `ready_o`=1.
- Reset packet: accept node 0, dnr 0, len 1, payload 1. Serial output is 1,0,0,0,0,0,1,1, then 2 zeros, then `ready_o`=1.
- Data packet: accept node 5, dnr 1, len 0. Serial output is 1,1,0,1,0,1,0 (7 bits), with `busy_o` high through GAP.
- Back-to-back: hold `v_i`=1 with two requests.
  - The second start bit appears exactly 11 cycles after the first.
  - With the macro defined, `pkt_count_o`=2 after both packets.
- Mid-packet reset: pull `aresetn` low during the ID field.
  - `tag_data_o`=0 immediately.
  - After release, the full 16-cycle preamble repeats with no residual bits.
- Clamp: with `tag_max_payload_width_p`=2 and `len_i`=3, the block transmits a length field of 2 and exactly 2 payload bits.

Source files
------------

// File: rtl/zynq_tag_serializer.sv
// zynq_tag_serializer: bit-serial bsg_tag packet generator for bsg_tag_master (preamble, packet, gap).
// Define ZYNQ_TAG_SERIALIZER_PKT_COUNT_EN to add the 32-bit pkt_count_o packet counter output.
module zynq_tag_serializer #(
    parameter int tag_els_p               = 16,
    parameter int tag_max_payload_width_p = 1,
    parameter int lg_els_lp               = (tag_els_p > 1) ? $clog2(tag_els_p) : 1,
    parameter int lg_width_lp             = (tag_max_payload_width_p > 0)
                                            ? $clog2(tag_max_payload_width_p + 1) : 1,
    parameter int preamble_cycles_p       = 16,
    parameter int gap_cycles_p            = 2
) (
    input  logic                               aclk,
    input  logic                               aresetn,
    input  logic                               v_i,
    output logic                               ready_o,
    input  logic [lg_els_lp-1:0]               node_id_i,
    input  logic                               data_not_reset_i,
    input  logic [lg_width_lp-1:0]             len_i,
    input  logic [tag_max_payload_width_p-1:0] payload_i,
    output logic                               tag_data_o,
    output logic                               busy_o
`ifdef ZYNQ_TAG_SERIALIZER_PKT_COUNT_EN
    ,
    output logic [31:0]                        pkt_count_o
`endif
);

    localparam int shift_w_lp     = lg_els_lp + 1 + lg_width_lp + tag_max_payload_width_p;
    localparam int hdr_len_lp     = 2 + lg_els_lp + lg_width_lp;
    localparam int max_pkt_len_lp = hdr_len_lp + tag_max_payload_width_p;
    localparam int cnt_w_lp       = $clog2(max_pkt_len_lp + 1);
    localparam int timer_max_lp   = (preamble_cycles_p > gap_cycles_p) ? preamble_cycles_p
                                                                       : gap_cycles_p;
    localparam int timer_w_lp     = (timer_max_lp > 1) ? $clog2(timer_max_lp + 1) : 1;
    localparam int pre_last_lp    = (preamble_cycles_p > 0) ? preamble_cycles_p - 1 : 0;
    localparam int gap_last_lp    = (gap_cycles_p > 0) ? gap_cycles_p - 1 : 0;

    localparam logic [1:0] ST_PRE  = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    logic [1:0]             state_q, state_d;
    logic [timer_w_lp-1:0]  timer_q, timer_d;
    logic [cnt_w_lp-1:0]    cnt_q, cnt_d;
    logic [shift_w_lp-1:0]  shift_q, shift_d;
    logic                   tag_data_q, tag_data_d;

    logic                   accept;
    logic [lg_width_lp-1:0] len_clamped;
    logic [cnt_w_lp-1:0]    pkt_len;

    assign ready_o    = (state_q == ST_IDLE);
    assign busy_o     = (state_q != ST_IDLE);
    assign tag_data_o = tag_data_q;
    assign accept     = v_i & ready_o;

    // Oversized requests are clamped so the length field and payload agree on the wire.
    always_comb begin
        if (32'(len_i) > tag_max_payload_width_p) begin
            len_clamped = lg_width_lp'(tag_max_payload_width_p);
        end else begin
            len_clamped = len_i;
        end
        pkt_len = cnt_w_lp'(hdr_len_lp) + cnt_w_lp'(len_clamped);
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        tag_data_d = 1'b0;

        case (state_q)
            ST_PRE: begin
                timer_d = timer_q + timer_w_lp'(1);
                if (timer_q == timer_w_lp'(pre_last_lp)) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end
            end

            ST_IDLE: begin
                if (accept) begin
                    // Start bit goes straight to the output flop; the rest waits in the shifter.
                    state_d    = ST_SEND;
                    tag_data_d = 1'b1;
                    cnt_d      = pkt_len;
                    shift_d    = {payload_i, len_clamped, data_not_reset_i, node_id_i};
                end
            end

            ST_SEND: begin
                // cnt_q counts the bit currently on the wire plus all bits still to come.
                if (cnt_q == cnt_w_lp'(1)) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                    timer_d = '0;
                end else begin
                    tag_data_d = shift_q[0];
                    shift_d    = {1'b0, shift_q[shift_w_lp-1:1]};
                    cnt_d      = cnt_q - cnt_w_lp'(1);
                end
            end

            ST_GAP: begin
                timer_d = timer_q + timer_w_lp'(1);
                if (timer_q == timer_w_lp'(gap_last_lp)) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end
            end

            default: begin
                state_d = ST_PRE;
                timer_d = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= ST_PRE;
            timer_q    <= '0;
            cnt_q      <= '0;
            shift_q    <= '0;
            tag_data_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            tag_data_q <= tag_data_d;
        end
    end

`ifdef ZYNQ_TAG_SERIALIZER_PKT_COUNT_EN
    logic [31:0] pkt_count_q, pkt_count_d;

    // Counts on the edge that loads the final packet bit, so it steps with that bit on the wire.
    always_comb begin
        pkt_count_d = pkt_count_q;
        if ((state_q == ST_SEND) && (cnt_q == cnt_w_lp'(2))) begin
            pkt_count_d = pkt_count_q + 32'd1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pkt_count_q <= '0;
        end else begin
            pkt_count_q <= pkt_count_d;
        end
    end

    assign pkt_count_o = pkt_count_q;
`endif

endmodule

// File: tb/tb_zynq_tag_serializer.sv
// Scoreboard bench for zynq_tag_serializer: default instance plus a 2-bit-payload instance for clamping.
// Expected serial bits are pushed at accept time and compared every cycle against tag_data_o.
module tb_zynq_tag_serializer;

    localparam int PRE = 16;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        v_a, v_w;
    logic [3:0]  node_id;
    logic        dnr;
    logic [1:0]  len;
    logic [1:0]  payload;
    logic        ready_a, ready_w, tag_a, tag_w, busy_a, busy_w;
`ifdef ZYNQ_TAG_SERIALIZER_PKT_COUNT_EN
    logic [31:0] cnt_a, cnt_w;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    logic [1:0] exp_a[$];
    logic [1:0] exp_w[$];
    int         start_cyc[$];
    int         cyc    = 0;
    int         pkts_a = 0;
    int         pkts_w = 0;

    always #5 aclk = ~aclk;

    zynq_tag_serializer #(
        .tag_els_p(16), .tag_max_payload_width_p(1),
        .preamble_cycles_p(PRE), .gap_cycles_p(2)
    ) dut_a (
        .aclk(aclk), .aresetn(aresetn), .v_i(v_a), .ready_o(ready_a),
        .node_id_i(node_id), .data_not_reset_i(dnr), .len_i(len[0:0]),
        .payload_i(payload[0:0]), .tag_data_o(tag_a), .busy_o(busy_a)
`ifdef ZYNQ_TAG_SERIALIZER_PKT_COUNT_EN
        , .pkt_count_o(cnt_a)
`endif
    );

    zynq_tag_serializer #(
        .tag_els_p(16), .tag_max_payload_width_p(2),
        .preamble_cycles_p(PRE), .gap_cycles_p(2)
    ) dut_w (
        .aclk(aclk), .aresetn(aresetn), .v_i(v_w), .ready_o(ready_w),
        .node_id_i(node_id), .data_not_reset_i(dnr), .len_i(len),
        .payload_i(payload), .tag_data_o(tag_w), .busy_o(busy_w)
`ifdef ZYNQ_TAG_SERIALIZER_PKT_COUNT_EN
        , .pkt_count_o(cnt_w)
`endif
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Every cycle: pop the next expected bit, or expect an idle zero when nothing is queued.
    always @(negedge aclk) begin : monitor
        logic [1:0] ea, ew;
        cyc++;
        ea = (exp_a.size() != 0) ? exp_a.pop_front() : 2'b00;
        ew = (exp_w.size() != 0) ? exp_w.pop_front() : 2'b00;
        if (ea[1]) start_cyc.push_back(cyc);
        check("serial_a", {31'd0, tag_a}, {31'd0, ea[0]});
        check("serial_w", {31'd0, tag_w}, {31'd0, ew[0]});
    end

    task automatic send(input bit sel_w, input logic [3:0] nid, input logic d,
                        input logic [1:0] l, input logic [1:0] p, input bit hold);
        logic [1:0] bits[$];
        int mw, cl, guard;
        @(negedge aclk);
        node_id = nid;
        dnr     = d;
        len     = l;
        payload = p;
        if (sel_w) v_w = 1'b1; else v_a = 1'b1;
        guard = 0;
        while (!(sel_w ? ready_w : ready_a) && guard < 200) begin
            @(negedge aclk);
            guard++;
        end
        if (guard >= 200) begin
            check("accept_timeout", 32'(guard), 0);
            v_a = 1'b0;
            v_w = 1'b0;
            return;
        end
        @(posedge aclk);
        #1;
        if (!hold) begin
            v_a = 1'b0;
            v_w = 1'b0;
        end
        mw = sel_w ? 2 : 1;
        cl = sel_w ? int'(l) : int'(l[0]);
        if (cl > mw) cl = mw;
        bits.push_back(2'b11);
        for (int i = 0; i < 4; i++) bits.push_back({1'b0, nid[i]});
        bits.push_back({1'b0, d});
        for (int i = 0; i < mw; i++) bits.push_back({1'b0, cl[i]});
        for (int i = 0; i < cl; i++) bits.push_back({1'b0, p[i]});
        foreach (bits[i]) begin
            if (sel_w) exp_w.push_back(bits[i]); else exp_a.push_back(bits[i]);
        end
        if (sel_w) pkts_w++; else pkts_a++;
    endtask

    task automatic drain();
        int guard = 0;
        while ((exp_a.size() != 0 || exp_w.size() != 0) && guard < 300) begin
            @(posedge aclk);
            guard++;
        end
        check("drain_timeout", {31'd0, guard >= 300}, 0);
`ifdef ZYNQ_TAG_SERIALIZER_PKT_COUNT_EN
        check("pkt_count_a", cnt_a, 32'(pkts_a));
        check("pkt_count_w", cnt_w, 32'(pkts_w));
`endif
    endtask

    // Called right after drain: two GAP cycles busy and not ready, then IDLE.
    task automatic check_gap_a();
        for (int i = 0; i < 2; i++) begin
            @(negedge aclk);
            check("gap_busy", {31'd0, busy_a}, 1);
            check("gap_ready", {31'd0, ready_a}, 0);
        end
        @(negedge aclk);
        check("idle_ready", {31'd0, ready_a}, 1);
        check("idle_busy", {31'd0, busy_a}, 0);
    endtask

    task automatic do_reset();
        int n;
        aresetn = 1'b0;
        exp_a.delete();
        exp_w.delete();
        pkts_a = 0;
        pkts_w = 0;
        #1;
        check("rst_tag_a", {31'd0, tag_a}, 0);
        check("rst_ready_a", {31'd0, ready_a}, 0);
        check("rst_busy_a", {31'd0, busy_a}, 1);
        check("rst_tag_w", {31'd0, tag_w}, 0);
`ifdef ZYNQ_TAG_SERIALIZER_PKT_COUNT_EN
        check("rst_pkt_count", cnt_a, 0);
`endif
        @(negedge aclk);
        aresetn = 1'b1;
        n = 0;
        do begin
            @(posedge aclk);
            #1;
            n++;
        end while (!ready_a && n < 100);
        check("preamble_cycles", 32'(n), PRE);
        check("preamble_ready_w", {31'd0, ready_w}, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog expired");
    end

    initial begin
        aresetn = 1'b0;
        v_a = 1'b0;
        v_w = 1'b0;
        node_id = '0;
        dnr = 1'b0;
        len = '0;
        payload = '0;
        #12;
        do_reset();

        // Client reset packet: 1,0,0,0,0,0,1,1.
        send(0, 4'd0, 1'b0, 2'd1, 2'b01, 0);
        drain();
        check_gap_a();

        // Data packet: 1,1,0,1,0,1,0.
        send(0, 4'd5, 1'b1, 2'd0, 2'b00, 0);
        drain();
        check_gap_a();

        // Back-to-back with v_i held: start bits 11 cycles apart.
        start_cyc.delete();
        send(0, 4'd9, 1'b1, 2'd1, 2'b01, 1);
        send(0, 4'd6, 1'b0, 2'd1, 2'b00, 0);
        drain();
        check("b2b_starts", 32'(start_cyc.size()), 2);
        if (start_cyc.size() >= 2) check("b2b_spacing", 32'(start_cyc[1] - start_cyc[0]), 11);
        check_gap_a();

        // Clamp on the 2-bit instance: len 3 carries length field 2 and two payload bits.
        send(1, 4'd3, 1'b1, 2'd3, 2'b10, 0);
        drain();
        send(1, 4'd12, 1'b1, 2'd1, 2'b11, 0);
        drain();

        // Assorted requests on both instances.
        for (int i = 0; i < 6; i++) begin
            send(i[0], 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 0);
        end
        drain();

        // Reset during the ID field of an all-ones node ID.
        send(0, 4'd15, 1'b1, 2'd1, 2'b01, 0);
        @(negedge aclk);
        @(negedge aclk);
        check("mid_pkt_tag_high", {31'd0, tag_a}, 1);
        #2;
        do_reset();
        send(0, 4'd10, 1'b0, 2'd1, 2'b01, 0);
        drain();
        check_gap_a();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
